// File: rtl/prog_pkg.sv
// Shared definitions for the programmer path: dump FSM states, UART frame
// constants and the end-of-image marker word.
package prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_SEND,
    ST_TERM,
    ST_FIN
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_e;

  // End-of-image marker, shared with the ICCM controller.
  localparam logic [31:0] PROG_END_WORD = 32'h0000_0FFF;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_prog.sv
// UART 8N1 transmitter, transmit counterpart of the programmer receiver.
// tx_done_o fires in the last stop-bit cycle so a byte presented with
// tx_dv_i in that same cycle starts with no idle gap.
module uart_tx_prog
  import prog_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] clks_per_bit_i,
  input  logic        tx_dv_i,
  input  logic [7:0]  tx_byte_i,
  output logic        tx_o,
  output logic        tx_active_o,
  output logic        tx_done_o
);

  uart_tx_state_e state;
  logic [15:0]    bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     data;
  logic           last_tick;

  assign last_tick   = (bit_cnt == '0);
  assign tx_done_o   = (state == TX_STOP) && last_tick;
  assign tx_active_o = (state != TX_IDLE);

  // Frame sequencer: each bit is held clks_per_bit_i cycles (counted down to 0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= TX_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      data    <= '0;
      tx_o    <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          tx_o <= 1'b1;
          if (tx_dv_i) begin
            data    <= tx_byte_i;
            tx_o    <= 1'b0;
            bit_cnt <= clks_per_bit_i - 16'd1;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (last_tick) begin
            tx_o    <= data[0];
            bit_idx <= '0;
            bit_cnt <= clks_per_bit_i - 16'd1;
            state   <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (last_tick) begin
            bit_cnt <= clks_per_bit_i - 16'd1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              tx_o  <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= data[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (last_tick) begin
            if (tx_dv_i) begin
              data    <= tx_byte_i;
              tx_o    <= 1'b0;
              bit_cnt <= clks_per_bit_i - 16'd1;
              state   <= TX_START;
            end else begin
              tx_o  <= 1'b1;
              state <= TX_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/iccm_dump_tx.sv
// ICCM readback transmitter: reads words 0..count-1 from the SRAM read port
// and sends them LSB-first over UART 8N1, followed by the end-marker word.
module iccm_dump_tx
  import prog_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] word_count_i,
  input  logic [15:0]   clks_per_bit_i,
  output logic          rd_csb_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          tx_o,
  output logic          tx_en_o,
  output logic          busy_o,
  output logic          done_o
);

  dump_state_e   state;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] count_q;
  logic [15:0]   cpb_q;
  logic [DW-1:0] shift_word;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic          term_primed;
  logic          term_mode;
  logic          ser_dv;
  logic [7:0]    ser_byte;
  logic          ser_active;
  logic          ser_done;

  assign rd_addr_o = addr;
  assign addr_inc  = addr + AW'(1);
  assign idx_n     = idx + 2'd1;

  // Next byte for the serializer: issued in the same cycle as the previous
  // byte's last stop bit, so byte selection looks one index ahead in SEND.
  always_comb begin
    ser_dv   = 1'b0;
    ser_byte = shift_word[{idx_n, 3'b000} +: 8];
    case (state)
      ST_CAP: begin
        ser_dv   = 1'b1;
        ser_byte = rd_data_i[7:0];
      end
      ST_TERM: begin
        ser_dv   = term_primed;
        ser_byte = shift_word[7:0];
      end
      ST_SEND: ser_dv = ser_done && (idx != 2'd3);
      default: ser_dv = 1'b0;
    endcase
  end

  // Dump sequencer; TERM spends one cycle loading the marker so the gap
  // before the terminator matches the RD+CAP gap between data words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      addr        <= '0;
      count_q     <= '0;
      cpb_q       <= '0;
      shift_word  <= '0;
      idx         <= '0;
      term_primed <= 1'b0;
      term_mode   <= 1'b0;
      rd_csb_o    <= 1'b1;
      tx_en_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !ser_active) begin
            count_q   <= word_count_i;
            cpb_q     <= (clks_per_bit_i == '0) ? 16'd1 : clks_per_bit_i;
            addr      <= '0;
            term_mode <= 1'b0;
            busy_o    <= 1'b1;
            if (word_count_i != '0) begin
              rd_csb_o <= 1'b0;
              state    <= ST_RD;
            end else begin
              term_primed <= 1'b0;
              state       <= ST_TERM;
            end
          end
        end
        ST_RD: begin
          rd_csb_o <= 1'b1;
          state    <= ST_CAP;
        end
        ST_CAP: begin
          shift_word <= rd_data_i;
          idx        <= '0;
          tx_en_o    <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (ser_done) begin
            if (idx == 2'd3) begin
              if (term_mode) begin
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                tx_en_o <= 1'b0;
                state   <= ST_FIN;
              end else begin
                addr <= addr_inc;
                if (addr_inc == count_q) begin
                  term_primed <= 1'b0;
                  state       <= ST_TERM;
                end else begin
                  rd_csb_o <= 1'b0;
                  state    <= ST_RD;
                end
              end
            end else begin
              idx <= idx_n;
            end
          end
        end
        ST_TERM: begin
          if (!term_primed) begin
            shift_word  <= PROG_END_WORD;
            term_primed <= 1'b1;
          end else begin
            idx       <= '0;
            term_mode <= 1'b1;
            tx_en_o   <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_prog u_uart_tx (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clks_per_bit_i (cpb_q),
    .tx_dv_i        (ser_dv),
    .tx_byte_i      (ser_byte),
    .tx_o           (tx_o),
    .tx_active_o    (ser_active),
    .tx_done_o      (ser_done)
  );

endmodule

// File: tb/tb_iccm_dump_tx.sv
// Self-checking bench for iccm_dump_tx: expected line waveform, byte stream,
// read schedule and done timing are built from the framing rules.
module tb_iccm_dump_tx;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] word_count_i = '0;
  logic [15:0]   clks_per_bit_i = 16'd1;
  logic          rd_csb_o;
  logic [AW-1:0] rd_addr_o;
  logic [31:0]   rd_data_i = '0;
  logic          tx_o;
  logic          tx_en_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  bit tr_tx[$];
  bit tr_en[$];
  int rd_cyc[$];
  int rd_adr[$];

  iccm_dump_tx #(.AW(AW), .DW(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .word_count_i   (word_count_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rd_csb_o       (rd_csb_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_i      (rd_data_i),
    .tx_o           (tx_o),
    .tx_en_o        (tx_en_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM model
  always @(posedge clk) if (!rd_csb_o) rd_data_i <= mem[rd_addr_o];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input int w, input int n_in, input int disturb);
    int n = (n_in == 0) ? 1 : n_in;
    byte unsigned exp_bytes[$];
    byte unsigned got_bytes[$];
    bit exp_tx[$];
    bit exp_en[$];
    int cyc;
    int d_got;
    int d_exp;
    int busy_bad = 0;
    int wave_bad = 0;
    int en_bad = 0;
    int frame_bad = 0;
    int i;
    logic [31:0] word;
    logic [9:0] frame;
    byte unsigned v;

    for (int it = 0; it <= w; it++) begin
      word = (it < w) ? mem[it] : 32'h0000_0FFF;
      for (int b = 0; b < 4; b++) exp_bytes.push_back(word[8*b +: 8]);
    end
    exp_tx.push_back(1'b1); exp_tx.push_back(1'b1);
    exp_en.push_back(1'b0); exp_en.push_back(1'b0);
    for (int it = 0; it <= w; it++) begin
      for (int b = 0; b < 4; b++) begin
        frame = {1'b1, exp_bytes[it*4+b], 1'b0};
        for (int k = 0; k < 10; k++)
          for (int r = 0; r < n; r++) begin
            exp_tx.push_back(frame[k]);
            exp_en.push_back(1'b1);
          end
      end
      if (it < w) begin
        exp_tx.push_back(1'b1); exp_tx.push_back(1'b1);
        exp_en.push_back(1'b1); exp_en.push_back(1'b1);
      end
    end
    exp_tx.push_back(1'b1);
    exp_en.push_back(1'b0);
    d_exp = exp_tx.size();

    tr_tx.delete(); tr_en.delete(); rd_cyc.delete(); rd_adr.delete();

    @(negedge clk);
    start_i = 1'b1;
    word_count_i = w[AW-1:0];
    clks_per_bit_i = n_in[15:0];
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    d_got = -1;
    while (1) begin
      tr_tx.push_back(tx_o);
      tr_en.push_back(tx_en_o);
      if (!rd_csb_o) begin
        rd_cyc.push_back(cyc);
        rd_adr.push_back(int'(rd_addr_o));
      end
      if (done_o) begin
        d_got = cyc;
        break;
      end
      if (!busy_o) busy_bad++;
      if (cyc > d_exp + 20) break;
      if (disturb > 0 && cyc == disturb) begin
        start_i = 1'b1;
        word_count_i = AW'($urandom);
        clks_per_bit_i = 16'd9;
      end
      if (disturb > 0 && cyc == disturb + 1) start_i = 1'b0;
      @(negedge clk);
      cyc++;
    end

    chk($sformatf("done_cycle w=%0d n=%0d", w, n_in), d_got, d_exp);
    chk("busy_during_dump", busy_bad, 0);

    for (int j = 0; j < exp_tx.size(); j++) begin
      if (j >= tr_tx.size() || tr_tx[j] != exp_tx[j]) wave_bad++;
      if (j >= tr_en.size() || tr_en[j] != exp_en[j]) en_bad++;
    end
    chk("tx_wave_bad_cycles", wave_bad, 0);
    chk("tx_en_bad_cycles", en_bad, 0);

    i = 0;
    while (i < tr_tx.size()) begin
      if (tr_tx[i] == 1'b0) begin
        v = 8'h00;
        for (int k = 1; k <= 8; k++) begin
          if (i + n/2 + k*n < tr_tx.size()) v[k-1] = tr_tx[i + n/2 + k*n];
          else frame_bad++;
        end
        if (i + n/2 + 9*n >= tr_tx.size() || tr_tx[i + n/2 + 9*n] != 1'b1) frame_bad++;
        got_bytes.push_back(v);
        i += 10*n;
      end else begin
        i++;
      end
    end
    chk("byte_count", got_bytes.size(), exp_bytes.size());
    for (int j = 0; j < exp_bytes.size() && j < got_bytes.size(); j++)
      chk($sformatf("byte%0d", j), 32'(got_bytes[j]), 32'(exp_bytes[j]));
    chk("frame_errors", frame_bad, 0);

    chk("read_count", rd_cyc.size(), w);
    for (int j = 0; j < w && j < rd_cyc.size(); j++) begin
      chk($sformatf("rd_addr%0d", j), rd_adr[j], j);
      chk($sformatf("rd_cycle%0d", j), rd_cyc[j], 1 + j*(40*n + 2));
    end

    @(negedge clk);
    chk("done_pulse_width", 32'(done_o), 0);
    chk("busy_after_done", 32'(busy_o), 0);
  endtask

  initial begin
    int w;
    int n;
    for (int a = 0; a < (1<<AW); a++) mem[a] = $urandom;

    #12;
    chk("rst_tx", 32'(tx_o), 1);
    chk("rst_tx_en", 32'(tx_en_o), 0);
    chk("rst_csb", 32'(rd_csb_o), 1);
    chk("rst_addr", 32'(rd_addr_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 32'h1234_5678;
    run_dump(1, 4, 0);

    run_dump(0, 1, 0);

    mem[0] = 32'hA5A5_A5A5;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'hFFFF_FFFF;
    run_dump(3, 2, 0);

    mem[0] = $urandom;
    mem[1] = $urandom;
    run_dump(2, 3, 50);

    // Reset in the middle of data bit 0 of a zero byte
    mem[0] = 32'h5A5A_5A00;
    @(negedge clk);
    start_i = 1'b1;
    word_count_i = AW'(2);
    clks_per_bit_i = 16'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_tx", 32'(tx_o), 0);
    chk("pre_reset_busy", 32'(busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx_o), 1);
    chk("async_rst_tx_en", 32'(tx_en_o), 0);
    chk("async_rst_busy", 32'(busy_o), 0);
    chk("async_rst_csb", 32'(rd_csb_o), 1);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done_o), 0);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy_o), 0);
    mem[0] = $urandom;
    mem[1] = $urandom;
    run_dump(2, 2, 0);

    mem[0] = $urandom;
    mem[1] = $urandom;
    run_dump(2, 0, 0);

    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      for (int a = 0; a < w; a++) mem[a] = $urandom;
      run_dump(w, n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
